// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: conditional branches on stored Z/N flags,
// CALL/RET through a circular return-address stack, stall hold and external redirect.
module pc_sequencer #(
   parameter int unsigned         PC_W      = 10,
   parameter int unsigned         RAS_DEPTH = 4,
   parameter logic [PC_W-1:0]     RESET_PC  = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [3:0]                     branch_type,
   input  logic [PC_W-1:0]                branch_offset,
   input  logic [3:0]                     stored_flags,
   input  logic                           stall,
   input  logic                           redirect,
   input  logic [PC_W-1:0]                redirect_pc,
   output logic [PC_W-1:0]                pc,
   output logic                           taken,
   output logic [$clog2(RAS_DEPTH):0]     ras_count,
   output logic                           ras_ovf,
   output logic                           ras_unf
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [3:0] OP_JMP  = 4'd1;
   localparam logic [3:0] OP_BRZ  = 4'd2;
   localparam logic [3:0] OP_BRNZ = 4'd3;
   localparam logic [3:0] OP_BRNS = 4'd4;
   localparam logic [3:0] OP_CALL = 4'd5;
   localparam logic [3:0] OP_RET  = 4'd6;

   logic [PC_W-1:0]  pc_q, pc_d;
   logic             taken_q, taken_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [PC_W-1:0]  ras_q [RAS_DEPTH];

   logic             push;
   logic [PC_W-1:0]  seq_pc;
   logic [PC_W-1:0]  tgt_pc;
   logic [PTR_W-1:0] ptr_m1;
   logic             flag_z, flag_n;
   logic             unused_flags;

   assign seq_pc       = pc_q + PC_W'(1);
   assign tgt_pc       = pc_q + branch_offset;
   assign ptr_m1       = ptr_q - PTR_W'(1);
   assign flag_z       = stored_flags[0];
   assign flag_n       = stored_flags[1];
   assign unused_flags = ^stored_flags[3:2];

   always_comb begin
      pc_d    = seq_pc;
      taken_d = 1'b0;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      if (redirect) begin
         pc_d    = redirect_pc;
         taken_d = 1'b1;
      end else if (stall) begin
         pc_d    = pc_q;
      end else begin
         case (branch_type)
            OP_JMP:  begin pc_d = tgt_pc; taken_d = 1'b1; end
            OP_BRZ:  if (flag_z)  begin pc_d = tgt_pc; taken_d = 1'b1; end
            OP_BRNZ: if (!flag_z) begin pc_d = tgt_pc; taken_d = 1'b1; end
            OP_BRNS: if (!flag_n) begin pc_d = tgt_pc; taken_d = 1'b1; end
            OP_CALL: begin
               // Full stack: pointer already sits on the oldest entry, so the push overwrites it.
               push    = 1'b1;
               pc_d    = tgt_pc;
               taken_d = 1'b1;
               ptr_d   = ptr_q + PTR_W'(1);
               if (cnt_q == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
               else                            cnt_d = cnt_q + CNT_W'(1);
            end
            OP_RET: begin
               if (cnt_q != '0) begin
                  pc_d    = ras_q[ptr_m1];
                  taken_d = 1'b1;
                  ptr_d   = ptr_m1;
                  cnt_d   = cnt_q - CNT_W'(1);
               end else begin
                  unf_d   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         taken_q <= 1'b0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      end else begin
         pc_q    <= pc_d;
         taken_q <= taken_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         if (push) ras_q[ptr_q] <= seq_pc;
      end
   end

   assign pc        = pc_q;
   assign taken     = taken_q;
   assign ras_count = cnt_q;
   assign ras_ovf   = ovf_q;
   assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written RAS/stall/reset sequences,
// and random stimulus against a queue-based reference model.
module tb_pc_sequencer;

   localparam logic [3:0] NONE = 4'd0, JMP = 4'd1, BRZ = 4'd2, BRNZ = 4'd3,
                          BRNS = 4'd4, CALL = 4'd5, RET = 4'd6;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] branch_type, stored_flags;
   logic [9:0] branch_offset, redirect_pc, pc;
   logic       stall, redirect, taken, ras_ovf, ras_unf;
   logic [2:0] ras_count;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(.PC_W(10), .RAS_DEPTH(4), .RESET_PC(10'd0)) dut (
      .clk(clk), .rst_n(rst_n), .branch_type(branch_type), .branch_offset(branch_offset),
      .stored_flags(stored_flags), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .pc(pc), .taken(taken), .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [9:0] off;
      logic [3:0] fl;
      logic       st;
      logic       rd;
      logic [9:0] rpc;
      int         epc;
      int         etk;
      int         ecnt;
      int         eovf;
      int         eunf;
   } vec_t;

   vec_t tbl [14];

   // Reference model: PC as an integer mod 1024, RAS as a LIFO capped at 4 entries.
   int m_pc, m_tk, m_ovf, m_unf;
   int m_ras[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [9:0] off, input logic [3:0] fl,
                        input logic st, input logic rd, input logic [9:0] rpc);
      branch_type = op; branch_offset = off; stored_flags = fl;
      stall = st; redirect = rd; redirect_pc = rpc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(NONE, 10'd0, 4'd0, 1'b0, 1'b0, 10'd0);
      rst_n = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      m_pc = 0; m_tk = 0; m_ovf = 0; m_unf = 0;
      m_ras.delete();
   endtask

   task automatic model_step(input logic [3:0] op, input logic [9:0] off, input logic [3:0] fl,
                             input logic st, input logic rd, input logic [9:0] rpc);
      int cond;
      if (rd) begin
         m_pc = int'(rpc); m_tk = 1;
      end else if (st) begin
         m_tk = 0;
      end else begin
         case (op)
            JMP:     cond = 1;
            BRZ:     cond = int'(fl[0]);
            BRNZ:    cond = int'(!fl[0]);
            BRNS:    cond = int'(!fl[1]);
            CALL:    cond = 1;
            RET:     cond = (m_ras.size() != 0) ? 1 : 0;
            default: cond = 0;
         endcase
         if (op == RET && m_ras.size() == 0) m_unf = 1;
         if (cond == 0) begin
            m_pc = (m_pc + 1) % 1024;
         end else if (op == RET) begin
            m_pc = m_ras.pop_back();
         end else begin
            if (op == CALL) begin
               m_ras.push_back((m_pc + 1) % 1024);
               if (m_ras.size() > 4) begin
                  void'(m_ras.pop_front());
                  m_ovf = 1;
               end
            end
            m_pc = (m_pc + int'(off)) % 1024;
         end
         m_tk = cond;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(NONE, 10'd0, 4'd0, 1'b0, 1'b0, 10'd0);

      //           op    off      fl    st    rd    rpc       pc  tk cnt ovf unf
      tbl[0]  = '{NONE, 10'd0,   4'd0, 1'b0, 1'b0, 10'd0,     1,  0, 0, 0, 0};
      tbl[1]  = '{NONE, 10'd0,   4'd0, 1'b0, 1'b0, 10'd0,     2,  0, 0, 0, 0};
      tbl[2]  = '{NONE, 10'd0,   4'd0, 1'b0, 1'b0, 10'd0,     3,  0, 0, 0, 0};
      tbl[3]  = '{JMP,  10'd2,   4'd0, 1'b0, 1'b0, 10'd0,     5,  1, 0, 0, 0};
      tbl[4]  = '{BRZ,  10'h3FE, 4'd1, 1'b0, 1'b0, 10'd0,     3,  1, 0, 0, 0};
      tbl[5]  = '{BRZ,  10'h3FE, 4'd0, 1'b0, 1'b0, 10'd0,     4,  0, 0, 0, 0};
      tbl[6]  = '{BRNZ, 10'd6,   4'd0, 1'b0, 1'b0, 10'd0,    10,  1, 0, 0, 0};
      tbl[7]  = '{BRNS, 10'd5,   4'd2, 1'b0, 1'b0, 10'd0,    11,  0, 0, 0, 0};
      tbl[8]  = '{BRNS, 10'd5,   4'd0, 1'b0, 1'b0, 10'd0,    16,  1, 0, 0, 0};
      tbl[9]  = '{CALL, 10'd4,   4'd0, 1'b0, 1'b0, 10'd0,    20,  1, 1, 0, 0};
      tbl[10] = '{CALL, 10'd4,   4'd0, 1'b1, 1'b0, 10'd0,    20,  0, 1, 0, 0};
      tbl[11] = '{RET,  10'd0,   4'd0, 1'b1, 1'b1, 10'h100, 256,  1, 1, 0, 0};
      tbl[12] = '{RET,  10'd0,   4'd0, 1'b0, 1'b0, 10'd0,    17,  1, 0, 0, 0};
      tbl[13] = '{RET,  10'd0,   4'd0, 1'b0, 1'b0, 10'd0,    18,  0, 0, 0, 1};

      #3;
      chk("reset_pc", pc, 0);
      chk("reset_taken", taken, 0);
      chk("reset_count", ras_count, 0);
      chk("reset_flags", {ras_ovf, ras_unf}, 0);

      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].op, tbl[i].off, tbl[i].fl, tbl[i].st, tbl[i].rd, tbl[i].rpc);
         step();
         chk($sformatf("vec%0d_pc", i), pc, tbl[i].epc);
         chk($sformatf("vec%0d_taken", i), taken, tbl[i].etk);
         chk($sformatf("vec%0d_count", i), ras_count, tbl[i].ecnt);
         chk($sformatf("vec%0d_ovf", i), ras_ovf, tbl[i].eovf);
         chk($sformatf("vec%0d_unf", i), ras_unf, tbl[i].eunf);
      end

      // PC wrap: branch and sequential step across 0x3FF.
      drive(NONE, 10'd0, 4'd0, 1'b0, 1'b1, 10'h3FF); step();
      drive(JMP, 10'd2, 4'd0, 1'b0, 1'b0, 10'd0); step();
      chk("wrap_jmp", pc, 1);
      drive(NONE, 10'd0, 4'd0, 1'b0, 1'b1, 10'h3FF); step();
      drive(NONE, 10'd0, 4'd0, 1'b0, 1'b0, 10'd0); step();
      chk("wrap_seq", pc, 0);

      // Five CALLs into a 4-deep stack, then drain past empty.
      do_reset();
      drive(NONE, 10'd0, 4'd0, 1'b0, 1'b1, 10'd10); step();
      for (int i = 0; i < 5; i++) begin
         drive(CALL, 10'd10, 4'd0, 1'b0, 1'b0, 10'd0); step();
      end
      chk("call5_pc", pc, 60);
      chk("call5_count", ras_count, 4);
      chk("call5_ovf", ras_ovf, 1);
      for (int i = 0; i < 4; i++) begin
         drive(RET, 10'd0, 4'd0, 1'b0, 1'b0, 10'd0); step();
         chk($sformatf("ret%0d_pc", i), pc, 51 - 10 * i);
      end
      chk("ret_empty_count", ras_count, 0);
      chk("ret_empty_unf_before", ras_unf, 0);
      drive(RET, 10'd0, 4'd0, 1'b0, 1'b0, 10'd0); step();
      chk("ret5_pc", pc, 22);
      chk("ret5_taken", taken, 0);
      chk("ret5_unf", ras_unf, 1);
      chk("ret5_ovf_sticky", ras_ovf, 1);

      // Stalled CALL for 3 cycles, then released: exactly one push.
      do_reset();
      drive(NONE, 10'd0, 4'd0, 1'b0, 1'b0, 10'd0); step(); step();
      for (int i = 0; i < 3; i++) begin
         drive(CALL, 10'd8, 4'd0, 1'b1, 1'b0, 10'd0); step();
         chk($sformatf("stall%0d_pc", i), pc, 2);
         chk($sformatf("stall%0d_count", i), ras_count, 0);
         chk($sformatf("stall%0d_taken", i), taken, 0);
      end
      drive(CALL, 10'd8, 4'd0, 1'b0, 1'b0, 10'd0); step();
      chk("stall_rel_pc", pc, 10);
      chk("stall_rel_count", ras_count, 1);
      drive(RET, 10'd0, 4'd0, 1'b1, 1'b1, 10'h100); step();
      chk("redir_pc", pc, 10'h100);
      chk("redir_taken", taken, 1);
      chk("redir_count", ras_count, 1);

      // Asynchronous reset pulse between clock edges.
      drive(CALL, 10'd3, 4'd0, 1'b0, 1'b0, 10'd0); step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_pc", pc, 0);
      chk("async_taken", taken, 0);
      chk("async_count", ras_count, 0);
      chk("async_flags", {ras_ovf, ras_unf}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Random stimulus against the reference model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] op, fl;
         logic [9:0] off, rpc;
         logic st, rd;
         op  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
         off = 10'($urandom);
         fl  = 4'($urandom);
         st  = ($urandom_range(0, 7) == 0);
         rd  = ($urandom_range(0, 15) == 0);
         rpc = 10'($urandom);
         drive(op, off, fl, st, rd, rpc);
         model_step(op, off, fl, st, rd, rpc);
         step();
         chk("rand_pc", pc, m_pc);
         chk("rand_taken", taken, m_tk);
         chk("rand_count", ras_count, m_ras.size());
         chk("rand_ovf", ras_ovf, m_ovf);
         chk("rand_unf", ras_unf, m_unf);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
